// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO drain stage: read strobe, byte capture, async serial framing
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int RD_PULSE     = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        nempty,
    input  logic [7:0]  fifo_data,
    output logic        fiford,
    output logic        tx,
    output logic        busy,
    output logic [15:0] sent_count
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        START,
        DATA,
        PARITY,
        STOP,
        GAP
    } state_t;

    // Terminal counts for the shared cycle counter in each timed state.
    localparam logic [15:0] READ_LAST = 16'(RD_PULSE - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] STOP_LAST = 16'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift_reg, shift_reg_n;
    logic        parity_bit, parity_bit_n;
    logic        tx_q, tx_n;
    logic        fiford_q, fiford_n;
    logic        busy_q, busy_n;
    logic [15:0] sent_q, sent_n;

    // State and all output registers; reset forces the line idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'd0;
            parity_bit <= 1'b0;
            tx_q       <= 1'b1;
            fiford_q   <= 1'b1;
            busy_q     <= 1'b0;
            sent_q     <= 16'd0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shift_reg  <= shift_reg_n;
            parity_bit <= parity_bit_n;
            tx_q       <= tx_n;
            fiford_q   <= fiford_n;
            busy_q     <= busy_n;
            sent_q     <= sent_n;
        end
    end

    // Next-state logic; outputs are computed for the state being entered so
    // that tx/fiford/busy come straight from flops.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        bit_idx_n    = bit_idx;
        shift_reg_n  = shift_reg;
        parity_bit_n = parity_bit;
        tx_n         = tx_q;
        fiford_n     = fiford_q;
        busy_n       = busy_q;
        sent_n       = sent_q;

        case (state)
            IDLE: begin
                cnt_n    = 16'd0;
                tx_n     = 1'b1;
                fiford_n = 1'b1;
                busy_n   = 1'b0;
                if (enable && nempty) begin
                    state_n  = READ;
                    fiford_n = 1'b0;
                    busy_n   = 1'b1;
                end
            end

            READ: begin
                if (cnt == READ_LAST) begin
                    // Read data is valid by the end of the strobe; start bit begins here.
                    state_n      = START;
                    cnt_n        = 16'd0;
                    fiford_n     = 1'b1;
                    shift_reg_n  = fifo_data;
                    parity_bit_n = ^fifo_data;
                    tx_n         = 1'b0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end

            START: begin
                if (cnt == BIT_LAST) begin
                    state_n   = DATA;
                    cnt_n     = 16'd0;
                    bit_idx_n = 3'd0;
                    tx_n      = shift_reg[0];
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end

            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = 16'd0;
                    if (bit_idx == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                            tx_n    = parity_bit;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        // LSB is always on the line; shift the next bit down.
                        bit_idx_n   = bit_idx + 3'd1;
                        shift_reg_n = {1'b0, shift_reg[7:1]};
                        tx_n        = shift_reg[1];
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end

            PARITY: begin
                if (cnt == BIT_LAST) begin
                    state_n = STOP;
                    cnt_n   = 16'd0;
                    tx_n    = 1'b1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end

            STOP: begin
                if (cnt == STOP_LAST) begin
                    state_n = GAP;
                    cnt_n   = 16'd0;
                    sent_n  = sent_q + 16'd1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end

            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = IDLE;
                    cnt_n   = 16'd0;
                    busy_n  = 1'b0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end

            default: begin
                state_n  = IDLE;
                cnt_n    = 16'd0;
                tx_n     = 1'b1;
                fiford_n = 1'b1;
                busy_n   = 1'b0;
            end
        endcase
    end

    assign fiford     = fiford_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign sent_count = sent_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - scoreboard bench for fifo_uart_tx with FIFO and line models
module tb_fifo_uart_tx;

    localparam int C  = 4;
    localparam int RD = 4;
    localparam int GP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_w     [2];
    logic        nempty_w [2];
    logic [7:0]  fdata_w  [2];
    logic        fiford_w [2];
    logic        tx_w     [2];
    logic        busy_w   [2];
    logic [15:0] sent_w   [2];

    logic [7:0] fq   [2][$];
    logic [7:0] expq [2][$];
    int         falls[2][$];
    int         exp_sent[2];
    int         cyc = 0;
    int         nchk = 0;
    int         nerr = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(C), .RD_PULSE(RD), .GAP_CYCLES(GP), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .enable(en_w[0]), .nempty(nempty_w[0]), .fifo_data(fdata_w[0]),
        .fiford(fiford_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .sent_count(sent_w[0]));

    fifo_uart_tx #(.CLKS_PER_BIT(C), .RD_PULSE(RD), .GAP_CYCLES(GP), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .enable(en_w[1]), .nempty(nempty_w[1]), .fifo_data(fdata_w[1]),
        .fiford(fiford_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .sent_count(sent_w[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        nchk++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int frame_bits(input int k);
        return (k == 0) ? 10 : 11;
    endfunction

    task automatic fifo_update(input int k);
        nempty_w[k] = (fq[k].size() > 0);
        fdata_w[k]  = (fq[k].size() > 0) ? fq[k][0] : 8'h00;
    endtask

    task automatic push_byte(input int k, input logic [7:0] b);
        fq[k].push_back(b);
        expq[k].push_back(b);
        exp_sent[k]++;
        fifo_update(k);
    endtask

    // FIFO model and read-strobe timing: pulse width, read-to-start latency, pop on strobe end.
    task automatic strobe_mon(input int k);
        logic prev = 1'b1;
        int   low  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1;
                low  = 0;
                continue;
            end
            if (fiford_w[k] === 1'b0) begin
                if (prev) begin
                    falls[k].push_back(cyc);
                    low = 0;
                end
                low++;
            end else if (!prev) begin
                check($sformatf("rd_pulse_len%0d", k), low, RD);
                check($sformatf("read_to_start%0d", k), (tx_w[k] === 1'b0) ? 1 : 0, 1);
                if (fq[k].size() > 0) void'(fq[k].pop_front());
                fifo_update(k);
            end
            prev = fiford_w[k];
        end
    endtask

    // Line monitor: on a start bit, pop the expected byte and compare every cycle of the frame.
    task automatic frame_mon(input int k);
        logic [7:0] b;
        logic       bits[12];
        int         nb;
        bit         ok;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (rst || tx_w[k] !== 1'b0) continue;
            if (expq[k].size() == 0) begin
                check($sformatf("unexpected_frame%0d", k), 1, 0);
                while (tx_w[k] === 1'b0 && !rst) @(negedge clk);
                continue;
            end
            b  = expq[k].pop_front();
            nb = frame_bits(k);
            bits[0] = 1'b0;
            for (int j = 0; j < 8; j++) bits[1 + j] = b[j];
            if (k == 1) bits[9] = ($countones(b) % 2 == 1);
            bits[nb - 1] = 1'b1;
            ok = 1'b1;
            aborted = 1'b0;
            for (int i = 0; i < nb * C; i++) begin
                if (i > 0) @(negedge clk);
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
                if (tx_w[k] !== bits[i / C]) ok = 1'b0;
                if (fiford_w[k] !== 1'b1) ok = 1'b0;
                if (busy_w[k] !== 1'b1) ok = 1'b0;
            end
            if (!aborted) check($sformatf("frame%0d_byte%02h", k, b), ok, 1);
        end
    endtask

    initial fork
        strobe_mon(0);
        strobe_mon(1);
        frame_mon(0);
        frame_mon(1);
    join_none

    task automatic wait_drain(input int k);
        int t = 0;
        while ((fq[k].size() != 0 || expq[k].size() != 0 || busy_w[k] !== 1'b0) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("drain_in_time%0d", k), (t < 20000) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n0;
        int n1;
        int bad;
        int spacing;
        logic [7:0] rb;

        for (int k = 0; k < 2; k++) begin
            en_w[k] = 1'b1;
            exp_sent[k] = 0;
            fifo_update(k);
        end
        #1 rst = 1'b1;

        // Reset held with data waiting: line idle, no strobe.
        push_byte(0, 8'hA5);
        push_byte(1, 8'h07);
        push_byte(1, 8'h03);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (fiford_w[0] !== 1'b1 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
            if (fiford_w[1] !== 1'b1 || tx_w[1] !== 1'b1 || busy_w[1] !== 1'b0) bad++;
        end
        check("reset_outputs_idle", bad, 0);
        check("reset_sent0", sent_w[0], 0);
        check("reset_falls", falls[0].size() + falls[1].size(), 0);
        rst = 1'b0;

        // Single byte A5 and the two parity bytes.
        wait_drain(0);
        wait_drain(1);
        check("single_sent0", sent_w[0], exp_sent[0]);
        check("parity_sent1", sent_w[1], exp_sent[1]);
        check("parity_spacing", falls[1][1] - falls[1][0], RD + 11 * C + GP + 1);
        n0 = falls[0].size();
        repeat (30) @(negedge clk);
        check("idle_no_read", falls[0].size(), n0);

        // Back-to-back frames.
        n0 = falls[0].size();
        n1 = falls[1].size();
        push_byte(0, 8'h00);
        push_byte(0, 8'hFF);
        push_byte(0, 8'h3C);
        for (int i = 0; i < 3; i++) push_byte(1, 8'($urandom));
        wait_drain(0);
        wait_drain(1);
        for (int i = 0; i < 2; i++) begin
            check("b2b_spacing0", falls[0][n0 + i + 1] - falls[0][n0 + i], RD + 10 * C + GP + 1);
            check("b2b_spacing1", falls[1][n1 + i + 1] - falls[1][n1 + i], RD + 11 * C + GP + 1);
        end
        check("b2b_sent0", sent_w[0], exp_sent[0]);
        check("b2b_sent1", sent_w[1], exp_sent[1]);

        // Randomized traffic with random arrival spacing.
        for (int i = 0; i < 24; i++) begin
            rb = 8'($urandom);
            push_byte($urandom_range(0, 1), rb);
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        wait_drain(0);
        wait_drain(1);
        check("rand_sent0", sent_w[0], exp_sent[0]);
        check("rand_sent1", sent_w[1], exp_sent[1]);

        // Enable gating: nothing while low; a 2-cycle enable gives exactly one frame.
        en_w[0] = 1'b0;
        n0 = falls[0].size();
        push_byte(0, 8'h96);
        push_byte(0, 8'h69);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (fiford_w[0] !== 1'b1 || tx_w[0] !== 1'b1) bad++;
        end
        check("disabled_idle", bad, 0);
        check("disabled_no_read", falls[0].size(), n0);
        en_w[0] = 1'b1;
        repeat (2) @(negedge clk);
        en_w[0] = 1'b0;
        repeat (80) @(negedge clk);
        check("enable_one_read", falls[0].size(), n0 + 1);
        check("enable_fifo_left", fq[0].size(), 1);
        check("enable_sent0", sent_w[0], exp_sent[0] - 1);
        en_w[0] = 1'b1;
        wait_drain(0);
        check("enable_drain_sent0", sent_w[0], exp_sent[0]);

        // Asynchronous reset during data bit 3 of 8'h55 (bit 3 is 0).
        n0 = falls[0].size();
        push_byte(0, 8'h55);
        push_byte(0, 8'hC3);
        bad = 0;
        while (fiford_w[0] !== 1'b0 && bad < 100) begin
            @(negedge clk);
            bad++;
        end
        while (fiford_w[0] !== 1'b1 && bad < 100) begin
            @(negedge clk);
            bad++;
        end
        check("reset_test_read_seen", (bad < 100) ? 1 : 0, 1);
        repeat (C * 4 + 1) @(negedge clk);
        check("pre_reset_tx_bit3", tx_w[0], 0);
        check("pre_reset_busy", busy_w[0], 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx", tx_w[0], 1);
        check("async_rst_fiford", fiford_w[0], 1);
        check("async_rst_busy", busy_w[0], 0);
        check("async_rst_sent0", sent_w[0], 0);
        check("async_rst_sent1", sent_w[1], 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_sent[0] = 1;
        exp_sent[1] = 0;
        wait_drain(0);
        check("post_reset_sent0", sent_w[0], exp_sent[0]);
        check("post_reset_queue", expq[0].size() + expq[1].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
